// File: rtl/cam_pkg.sv
// Shared camera/framebuffer constants and the fb_dma state encoding.
// Also consumed by the camera interface and the software header generator.
package cam_pkg;

  localparam int unsigned CAM_FB_W    = 64;
  localparam int unsigned CAM_FB_H    = 32;
  localparam logic [15:0] CAM_FB_BASE = 16'h8000;

  // Each pixel occupies one 32-bit bus word on the camera side; destination packs 4 per word.
  localparam int unsigned PIX_ADDR_SHIFT = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_DONE
  } fb_dma_state_e;

endpackage

// File: rtl/fb_dma_if.sv
// Camera read bus and destination write bus seen by fb_dma (picorv32-style valid/ready).
interface fb_dma_if;
   logic        cam_valid;
   logic [15:0] cam_addr;
   logic [31:0] cam_rdata;
   logic        cam_ready;

   logic        mem_valid;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;

   modport master (
      output cam_valid, cam_addr,
      input  cam_rdata, cam_ready,
      output mem_valid, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ready
   );

   modport slave (
      input  cam_valid, cam_addr,
      output cam_rdata, cam_ready,
      input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
      output mem_ready
   );
endinterface

// File: rtl/fb_pack4.sv
// Four-lane byte packer: loads one byte lane at a time, cleared between words.
module fb_pack4 (
   input  logic        sys_clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        load,
   input  logic [1:0]  lane,
   input  logic [7:0]  din,
   output logic [31:0] word
);
   always_ff @(posedge sys_clk) begin
      if (reset || clear) word <= '0;
      else if (load)      word[{lane, 3'b000} +: 8] <= din;
   end
endmodule

// File: rtl/fb_dma.sv
// Framebuffer copy engine: reads camera pixels, packs 4 per word, writes them to a destination.
// Optional FB_DMA_CHECKSUM_EN adds a 24-bit per-frame pixel sum on the checksum port.
module fb_dma
   import cam_pkg::*;
#(
   parameter int unsigned FB_W    = CAM_FB_W,
   parameter int unsigned FB_H    = CAM_FB_H,
   parameter logic [15:0] FB_BASE = CAM_FB_BASE
) (
   input  logic        sys_clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] dst_base,
   output logic        busy,
   output logic        done,
`ifdef FB_DMA_CHECKSUM_EN
   output logic [23:0] checksum,
`endif
   fb_dma_if.master    bus
);
   localparam int unsigned X_W   = $clog2(FB_W);
   localparam int unsigned Y_W   = $clog2(FB_H);
   localparam int unsigned IDX_W = $clog2(FB_W * FB_H);

   fb_dma_state_e  state, state_n;
   logic [X_W-1:0] x, x_n;
   logic [Y_W-1:0] y, y_n;
   logic [IDX_W-1:0] idx;
   logic [31:0]    dst_q;
   logic           cam_valid, cam_valid_n, mem_valid, mem_valid_n;
   logic           cam_ack, mem_ack, accept, load, clear, last_pix;
   logic [31:0]    word;
   logic           unused_rdata;

   assign cam_ack  = cam_valid && bus.cam_ready;
   assign mem_ack  = mem_valid && bus.mem_ready;
   assign last_pix = (x == X_W'(FB_W - 1)) && (y == Y_W'(FB_H - 1));
   assign idx      = IDX_W'(y) * IDX_W'(FB_W) + IDX_W'(x);

   // NOTE: every variable gets a default first, so no branch can leave one unassigned and infer a latch.
   always_comb begin
      state_n = state;
      x_n     = x;
      y_n     = y;
      accept  = 1'b0;
      load    = 1'b0;
      clear   = 1'b0;
      unique case (state)
         ST_IDLE: if (start) begin
            state_n = ST_RD;
            accept  = 1'b1;
            clear   = 1'b1;
            x_n     = '0;
            y_n     = '0;
         end
         ST_RD: if (cam_ack) begin
            load = 1'b1;
            if (x[1:0] == 2'd3) state_n = ST_WR;
            else                x_n     = x + 1'b1;
         end
         ST_WR: if (mem_ack) begin
            clear   = 1'b1;
            state_n = last_pix ? ST_DONE : ST_RD;
            if (x == X_W'(FB_W - 1)) begin
               x_n = '0;
               y_n = y + 1'b1;
            end else begin
               x_n = x + 1'b1;
            end
         end
         ST_DONE: state_n = ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
      // Valids drop on the edge that sees ready, so a registered slave never double-acks.
      cam_valid_n = (state_n == ST_RD) && !cam_ack;
      mem_valid_n = (state_n == ST_WR) && !mem_ack;
   end

   // NOTE: non-blocking assignments so every register updates from the values before the edge.
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         x         <= '0;
         y         <= '0;
         cam_valid <= 1'b0;
         mem_valid <= 1'b0;
         dst_q     <= '0;
      end else begin
         state     <= state_n;
         x         <= x_n;
         y         <= y_n;
         cam_valid <= cam_valid_n;
         mem_valid <= mem_valid_n;
         if (accept) dst_q <= dst_base;
      end
   end

   fb_pack4 u_pack (
      .sys_clk (sys_clk),
      .reset   (reset),
      .clear   (clear),
      .load    (load),
      .lane    (x[1:0]),
      .din     (bus.cam_rdata[7:0]),
      .word    (word)
   );

`ifdef FB_DMA_CHECKSUM_EN
   logic [23:0] acc;

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         acc      <= '0;
         checksum <= '0;
      end else begin
         if (accept)    acc <= '0;
         else if (load) acc <= acc + 24'(bus.cam_rdata[7:0]);
         if (state == ST_DONE) checksum <= acc;
      end
   end
`endif

   assign unused_rdata  = ^bus.cam_rdata[31:8];
   assign busy          = (state != ST_IDLE);
   assign done          = (state == ST_DONE);
   assign bus.cam_valid = cam_valid;
   assign bus.cam_addr  = FB_BASE + (16'(idx) << PIX_ADDR_SHIFT);
   assign bus.mem_valid = mem_valid;
   assign bus.mem_addr  = dst_q + (32'(idx >> PIX_ADDR_SHIFT) << PIX_ADDR_SHIFT);
   assign bus.mem_wdata = word;
   assign bus.mem_wstrb = mem_valid ? 4'b1111 : 4'b0000;
endmodule

// File: tb/tb_fb_dma.sv
// Scoreboard bench for fb_dma: camera and destination bus models, per-scenario tasks.
module tb_fb_dma;
   logic        sys_clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] dst_base = '0;
   logic        busy, done;
`ifdef FB_DMA_CHECKSUM_EN
   logic [23:0] checksum;
`endif

   fb_dma_if bus ();

   fb_dma dut (
      .sys_clk  (sys_clk),
      .reset    (reset),
      .start    (start),
      .dst_base (dst_base),
      .busy     (busy),
      .done     (done),
`ifdef FB_DMA_CHECKSUM_EN
      .checksum (checksum),
`endif
      .bus      (bus)
   );

   always #5 sys_clk = ~sys_clk;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t         exp_q[$];
   wr_t         e;
   int          checks = 0, failures = 0;
   int          writes = 0, cam_acks = 0, done_cnt = 0;
   int          stall_max = 0, stall_left = 0;
   bit          all_ff = 1'b0;
   bit          pend = 1'b0, prev_ready = 1'b0;
   logic [31:0] pend_addr, pend_data;
   logic [31:0] first_addr, first_data, last_addr, last_data;

   function automatic logic [7:0] pixel(int x, int y);
      return all_ff ? 8'hFF : 8'((x + y) & 255);
   endfunction

   function automatic logic [31:0] cam_word(logic [15:0] addr);
      logic [15:0] off;
      int          idx;
      off = addr - 16'h8000;
      idx = int'(off) >> 2;
      return {24'hA5A5A5, pixel(idx % 64, idx / 64)};
   endfunction

   // Camera slave: ready registered one cycle after valid, single ack per request.
   always @(posedge sys_clk) begin
      if (reset) begin
         bus.cam_ready <= 1'b0;
         bus.cam_rdata <= '0;
      end else begin
         bus.cam_ready <= bus.cam_valid && !bus.cam_ready;
         if (bus.cam_valid && !bus.cam_ready) bus.cam_rdata <= cam_word(bus.cam_addr);
      end
   end

   // Destination slave with a random 0..stall_max wait per write.
   always @(posedge sys_clk) begin
      if (reset) begin
         bus.mem_ready <= 1'b0;
         stall_left    <= 0;
      end else if (bus.mem_ready) begin
         bus.mem_ready <= 1'b0;
         stall_left    <= $urandom_range(stall_max, 0);
      end else if (bus.mem_valid) begin
         if (stall_left == 0) bus.mem_ready <= 1'b1;
         else                 stall_left    <= stall_left - 1;
      end
   end

   // Monitor / scoreboard, sampled mid-cycle.
   always @(negedge sys_clk) begin
      if (reset) begin
         pend       = 1'b0;
         prev_ready = 1'b0;
      end else begin
         checks++;
         if (prev_ready && bus.cam_valid) begin
            failures++;
            $display("FAIL cam_valid_after_ready t=%0t got cam_valid=%b want 0", $time, bus.cam_valid);
         end
         prev_ready = bus.cam_ready;
         if (bus.cam_valid && bus.cam_ready) cam_acks++;

         checks++;
         if (bus.mem_wstrb !== (bus.mem_valid ? 4'hF : 4'h0)) begin
            failures++;
            $display("FAIL mem_wstrb t=%0t got %b valid=%b", $time, bus.mem_wstrb, bus.mem_valid);
         end

         if (pend) begin
            checks++;
            if (!bus.mem_valid || bus.mem_addr !== pend_addr || bus.mem_wdata !== pend_data) begin
               failures++;
               $display("FAIL mem_hold t=%0t got v=%b a=%h d=%h want a=%h d=%h", $time,
                        bus.mem_valid, bus.mem_addr, bus.mem_wdata, pend_addr, pend_data);
            end
         end

         if (bus.mem_valid && bus.mem_ready) begin
            pend = 1'b0;
            writes++;
            if (writes == 1) begin
               first_addr = bus.mem_addr;
               first_data = bus.mem_wdata;
            end
            last_addr = bus.mem_addr;
            last_data = bus.mem_wdata;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL mem_extra_write t=%0t got a=%h d=%h want none", $time, bus.mem_addr, bus.mem_wdata);
            end else begin
               e = exp_q.pop_front();
               if (bus.mem_addr !== e.addr || bus.mem_wdata !== e.data) begin
                  failures++;
                  $display("FAIL mem_write t=%0t got a=%h d=%h want a=%h d=%h", $time,
                           bus.mem_addr, bus.mem_wdata, e.addr, e.data);
               end
            end
         end else if (bus.mem_valid) begin
            pend      = 1'b1;
            pend_addr = bus.mem_addr;
            pend_data = bus.mem_wdata;
         end else begin
            pend = 1'b0;
         end

         if (done) done_cnt++;
      end
   end

   task automatic apply_reset();
      reset = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge sys_clk);
      reset    = 1'b0;
      writes   = 0;
      cam_acks = 0;
      done_cnt = 0;
      exp_q.delete();
   endtask

   task automatic push_frame(input logic [31:0] base);
      for (int w = 0; w < 512; w++) begin
         wr_t item;
         int  x0, y0;
         x0        = (4 * w) % 64;
         y0        = (4 * w) / 64;
         item.addr = base + 32'(4 * w);
         item.data = {pixel(x0 + 3, y0), pixel(x0 + 2, y0), pixel(x0 + 1, y0), pixel(x0, y0)};
         exp_q.push_back(item);
      end
   endtask

   task automatic pulse_start(input logic [31:0] base);
      @(negedge sys_clk);
      start    = 1'b1;
      dst_base = base;
      @(negedge sys_clk);
      start    = 1'b0;
      dst_base = 32'hDEAD_BEEC;
   endtask

   task automatic wait_done(input bit start_on_done);
      bit ok = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         @(negedge sys_clk);
         if (done) begin
            ok = 1'b1;
            if (start_on_done) begin
               start    = 1'b1;
               dst_base = 32'h0BAD_0000;
            end
            break;
         end
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL done_timeout got no done within 20000 cycles");
      end
      @(negedge sys_clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL busy_after_done got %b want 0", busy);
      end
   endtask

   task automatic check_counts(input string tag);
      repeat (3) @(negedge sys_clk);
      checks++;
      if (writes !== 512 || cam_acks !== 2048 || done_cnt !== 1 || exp_q.size() !== 0) begin
         failures++;
         $display("FAIL %s_counts got writes=%0d acks=%0d dones=%0d left=%0d want 512/2048/1/0",
                  tag, writes, cam_acks, done_cnt, exp_q.size());
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge sys_clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || bus.cam_valid !== 1'b0 ||
          bus.mem_valid !== 1'b0 || bus.mem_wstrb !== 4'h0) begin
         failures++;
         $display("FAIL reset_state got busy=%b done=%b cv=%b mv=%b ws=%b want all 0",
                  busy, done, bus.cam_valid, bus.mem_valid, bus.mem_wstrb);
      end
`ifdef FB_DMA_CHECKSUM_EN
      checks++;
      if (checksum !== 24'h0) begin
         failures++;
         $display("FAIL reset_checksum got %h want 000000", checksum);
      end
`endif
      apply_reset();
   endtask

   task automatic test_frame();
      apply_reset();
      stall_max = 0;
      push_frame(32'h0001_0000);
      pulse_start(32'h0001_0000);
      checks++;
      if (busy !== 1'b1) begin
         failures++;
         $display("FAIL busy_after_start got %b want 1", busy);
      end
      wait_done(1'b0);
      check_counts("frame");
      checks++;
      if (first_addr !== 32'h0001_0000 || first_data !== 32'h0302_0100) begin
         failures++;
         $display("FAIL first_word got a=%h d=%h want a=00010000 d=03020100", first_addr, first_data);
      end
      checks++;
      if (last_addr !== 32'h0001_07FC || last_data !== 32'h5E5D_5C5B) begin
         failures++;
         $display("FAIL last_word got a=%h d=%h want a=000107fc d=5e5d5c5b", last_addr, last_data);
      end
   endtask

   task automatic test_mem_stall();
      apply_reset();
      stall_max = 7;
      push_frame(32'h0002_0000);
      pulse_start(32'h0002_0000);
      wait_done(1'b0);
      check_counts("stall");
      stall_max = 0;
   endtask

   task automatic test_start_ignored();
      apply_reset();
      push_frame(32'h0003_0000);
      repeat (4) @(negedge sys_clk);
      pulse_start(32'h0003_0000);
      repeat (94) @(negedge sys_clk);
      pulse_start(32'h0004_0000);
      wait_done(1'b1);
      repeat (20) @(negedge sys_clk);
      check_counts("start_ignored");
      checks++;
      if (busy !== 1'b0 || bus.cam_valid !== 1'b0) begin
         failures++;
         $display("FAIL start_on_done got busy=%b cv=%b want 0/0", busy, bus.cam_valid);
      end
   endtask

   task automatic test_reset_mid();
      bit hit = 1'b0;
      apply_reset();
      push_frame(32'h0005_0000);
      pulse_start(32'h0005_0000);
      for (int i = 0; i < 5000; i++) begin
         @(negedge sys_clk);
         if (writes >= 37) begin
            hit = 1'b1;
            break;
         end
      end
      checks++;
      if (!hit) begin
         failures++;
         $display("FAIL mid_write_timeout got writes=%0d want 37", writes);
      end
      reset = 1'b1;
      @(negedge sys_clk);
      checks++;
      if (bus.cam_valid !== 1'b0 || bus.mem_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset got cv=%b mv=%b busy=%b done=%b want all 0",
                  bus.cam_valid, bus.mem_valid, busy, done);
      end
      checks++;
      if (done_cnt !== 0) begin
         failures++;
         $display("FAIL mid_reset_done got %0d want 0", done_cnt);
      end
      apply_reset();
      push_frame(32'h0005_0000);
      pulse_start(32'h0005_0000);
      wait_done(1'b0);
      check_counts("restart");
   endtask

`ifdef FB_DMA_CHECKSUM_EN
   task automatic test_checksum();
      apply_reset();
      all_ff = 1'b1;
      push_frame(32'h0000_0000);
      pulse_start(32'h0000_0000);
      repeat (200) @(negedge sys_clk);
      checks++;
      if (checksum !== 24'h0) begin
         failures++;
         $display("FAIL checksum_before_done got %h want 000000", checksum);
      end
      wait_done(1'b0);
      checks++;
      if (checksum !== 24'h07F800) begin
         failures++;
         $display("FAIL checksum_frame got %h want 07f800", checksum);
      end
      check_counts("checksum");
      all_ff = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_frame();
      test_mem_stall();
      test_start_ignored();
      test_reset_mid();
`ifdef FB_DMA_CHECKSUM_EN
      test_checksum();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
